// File: rtl/window_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_acc_pkg
// Purpose  : Width and lane-indexing helpers shared by window_accumulator.
// Revision : 1.0
// ============================================================================
package window_acc_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Headroom for TAPS summands keeps every in-window sum exact.
   function automatic int acc_width(input int in_w, input int taps);
      return in_w + clog2(taps);
   endfunction

   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/acc_lane.sv
`default_nettype none
// ============================================================================
// Module   : acc_lane
// Purpose  : One lane's window accumulator, result register and narrowing.
//            Narrowing saturates when WINDOW_ACC_SAT_EN is defined, else wraps.
// Revision : 1.0
// ============================================================================
module acc_lane
   import window_acc_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int OUT_W = 32,
   parameter int TAPS  = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             accept,
   input  logic             complete,
   input  logic [IN_W-1:0]  in_val,
   output logic [OUT_W-1:0] out_val
);

   localparam int ACC_W = acc_width(IN_W, TAPS);

   logic signed [ACC_W-1:0] acc_q, acc_d, sum;
   logic        [OUT_W-1:0] out_q, out_d, narrowed;

   always_comb sum = acc_q + ACC_W'($signed(in_val));

`ifdef WINDOW_ACC_SAT_EN
   localparam int WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
   localparam logic signed [WIDE_W-1:0] SAT_MAX =
      {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] SAT_MIN =
      {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [WIDE_W-1:0] wide;

   always_comb begin
      wide = WIDE_W'(sum);
      if (wide > SAT_MAX)
         narrowed = SAT_MAX[OUT_W-1:0];
      else if (wide < SAT_MIN)
         narrowed = SAT_MIN[OUT_W-1:0];
      else
         narrowed = wide[OUT_W-1:0];
   end
`else
   // Signed size cast truncates when narrowing and sign-extends when widening.
   always_comb narrowed = OUT_W'(sum);
`endif

   always_comb begin
      acc_d = acc_q;
      out_d = out_q;
      if (clear || complete)
         acc_d = '0;
      else if (accept)
         acc_d = sum;
      if (complete)
         out_d = narrowed;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign out_val = out_q;

endmodule
`default_nettype wire

// File: rtl/window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : window_accumulator
// Purpose  : CH-lane windowed accumulator, one result beat per TAPS inputs,
//            one-deep valid/ready output. Optional WINDOW_ACC_SAT_EN saturates.
// Revision : 1.0
// ============================================================================
module window_accumulator
   import window_acc_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int OUT_W = 32,
   parameter int CH    = 4,
   parameter int TAPS  = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*IN_W-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*OUT_W-1:0] out_data,
   output logic                out_last_tap
);

   localparam int CNT_W = (TAPS > 1) ? clog2(TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             last_tap_q, last_tap_d;
   logic             accept, complete;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   // A beat accepted alongside clear is swallowed, so it can never complete.
   assign complete = accept && !clear && (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      last_tap_d  = complete;
      if (clear || complete)
         cnt_d = '0;
      else if (accept)
         cnt_d = cnt_q + 1'b1;
      if (complete)
         out_valid_d = 1'b1;
      else if (out_valid_q && out_ready)
         out_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         last_tap_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         last_tap_q  <= last_tap_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_last_tap = last_tap_q;

   for (genvar k = 0; k < CH; k++) begin : g_lane
      acc_lane #(
         .IN_W  (IN_W),
         .OUT_W (OUT_W),
         .TAPS  (TAPS)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .clear    (clear),
         .accept   (accept),
         .complete (complete),
         .in_val   (in_data[lane_lo(k, IN_W) +: IN_W]),
         .out_val  (out_data[lane_lo(k, OUT_W) +: OUT_W])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_accumulator
// Purpose  : Directed, table-driven bench for window_accumulator (default,
//            narrow-output and single-tap builds). Honours WINDOW_ACC_SAT_EN.
// Revision : 1.0
// ============================================================================
module tb_window_accumulator;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Default build: CH=4, TAPS=9, 32-bit in/out
   logic         clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic         in_ready, out_valid, out_last_tap;
   logic [127:0] in_data = '0;
   logic [127:0] out_data;

   // Narrow-output build: CH=1, IN_W=32, OUT_W=16
   logic         n_clear = 1'b0, n_in_valid = 1'b0, n_out_ready = 1'b1;
   logic         n_in_ready, n_out_valid, n_last;
   logic [31:0]  n_in_data = '0;
   logic [15:0]  n_out_data;

   // Single-tap build: CH=2, 8-bit lanes, TAPS=1
   logic         t_clear = 1'b0, t_in_valid = 1'b0, t_out_ready = 1'b1;
   logic         t_in_ready, t_out_valid, t_last;
   logic [15:0]  t_in_data = '0;
   logic [15:0]  t_out_data;

   window_accumulator #(.IN_W(32), .OUT_W(32), .CH(4), .TAPS(9)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last_tap(out_last_tap));

   window_accumulator #(.IN_W(32), .OUT_W(16), .CH(1), .TAPS(9)) dut_n (
      .clk(clk), .reset(reset), .clear(n_clear), .in_valid(n_in_valid),
      .in_ready(n_in_ready), .in_data(n_in_data), .out_valid(n_out_valid),
      .out_ready(n_out_ready), .out_data(n_out_data), .out_last_tap(n_last));

   window_accumulator #(.IN_W(8), .OUT_W(8), .CH(2), .TAPS(1)) dut_t (
      .clk(clk), .reset(reset), .clear(t_clear), .in_valid(t_in_valid),
      .in_ready(t_in_ready), .in_data(t_in_data), .out_valid(t_out_valid),
      .out_ready(t_out_ready), .out_data(t_out_data), .out_last_tap(t_last));

   typedef struct packed {
      logic [3:0][31:0] val;
      logic [3:0][31:0] exp;
   } vec_t;

   vec_t vecs [3];
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] splat(input logic [31:0] v);
      return {4{v}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [127:0] d, input logic clr);
      in_data  = d;
      in_valid = 1'b1;
      clear    = clr;
      tick();
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic check_lanes(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
      check({name, "_l0"}, out_data[31:0],   e0);
      check({name, "_l1"}, out_data[63:32],  e1);
      check({name, "_l2"}, out_data[95:64],  e2);
      check({name, "_l3"}, out_data[127:96], e3);
   endtask

   initial begin
      logic saw_valid;
      logic [15:0] n_exp_pos, n_exp_neg;

      vecs[0].val = {32'd1, 32'd1, 32'd1, 32'd1};
      vecs[0].exp = {32'd9, 32'd9, 32'd9, 32'd9};
      vecs[1].val = {32'd100, 32'd0, 32'd3, -32'sd5};
      vecs[1].exp = {32'd900, 32'd0, 32'd27, -32'sd45};
      vecs[2].val = {32'd12345, -32'sd2, 32'd7, -32'sd1000};
      vecs[2].exp = {32'd111105, -32'sd18, 32'd63, -32'sd9000};

      // Reset state
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 128'd0);
      tick();
      reset = 1'b0;
      tick();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_last_tap", out_last_tap, 1'b0);

      // Table of full windows, out_ready held high
      for (int i = 0; i < 3; i++) begin
         for (int b = 0; b < 9; b++) begin
            beat(vecs[i].val, 1'b0);
            if (b == 7) check($sformatf("v%0d_early_valid", i), out_valid, 1'b0);
         end
         check($sformatf("v%0d_valid", i), out_valid, 1'b1);
         check($sformatf("v%0d_last_tap", i), out_last_tap, 1'b1);
         for (int k = 0; k < 4; k++)
            check($sformatf("v%0d_lane%0d", i, k), out_data[k*32 +: 32], vecs[i].exp[k]);
         tick();
         check($sformatf("v%0d_valid_drop", i), out_valid, 1'b0);
         check($sformatf("v%0d_last_drop", i), out_last_tap, 1'b0);
      end

      // Backpressure: result held, next beat stalls, one-cycle drain
      out_ready = 1'b0;
      for (int b = 0; b < 9; b++) beat({32'd1, 32'd2, 32'd3, 32'd4}, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check_lanes("bp_w1", 32'd36, 32'd27, 32'd18, 32'd9);
      in_data  = splat(32'd5);
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("bp_hold%0d_ready", c), in_ready, 1'b0);
         check($sformatf("bp_hold%0d_l0", c), out_data[31:0], 32'd36);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp_drained", out_valid, 1'b0);
      for (int b = 0; b < 8; b++) beat(splat(32'd5), 1'b0);
      check("bp_w2_valid", out_valid, 1'b1);
      check_lanes("bp_w2", 32'd45, 32'd45, 32'd45, 32'd45);
      out_ready = 1'b1;
      tick();
      check("bp_w2_drop", out_valid, 1'b0);

      // Clear aborts a partial window; the clearing beat is discarded
      for (int b = 0; b < 4; b++) beat(splat(32'd7), 1'b0);
      beat(splat(32'd7), 1'b1);
      saw_valid = 1'b0;
      for (int b = 0; b < 8; b++) begin
         beat(splat(32'd2), 1'b0);
         saw_valid = saw_valid | out_valid;
      end
      check("clr_no_early_out", saw_valid, 1'b0);
      beat(splat(32'd2), 1'b0);
      check("clr_valid", out_valid, 1'b1);
      check_lanes("clr", 32'd18, 32'd18, 32'd18, 32'd18);
      tick();

      // Async reset mid-window: partial sum lost
      for (int b = 0; b < 5; b++) beat(splat(32'd1), 1'b0);
      #2 reset = 1'b1;
      #1 check("rstw_valid", out_valid, 1'b0);
      #2 reset = 1'b0;
      for (int b = 0; b < 9; b++) beat(splat(32'd1), 1'b0);
      check("rstw_valid_after", out_valid, 1'b1);
      check_lanes("rstw", 32'd9, 32'd9, 32'd9, 32'd9);
      tick();

      // Async reset with a result pending
      out_ready = 1'b0;
      for (int b = 0; b < 9; b++) beat(splat(32'd3), 1'b0);
      check("rstp_pending", out_valid, 1'b1);
      check("rstp_pending_l0", out_data[31:0], 32'd27);
      #2 reset = 1'b1;
      #1;
      check("rstp_valid", out_valid, 1'b0);
      check("rstp_data", out_data, 128'd0);
      check("rstp_last_tap", out_last_tap, 1'b0);
      check("rstp_in_ready", in_ready, 1'b1);
      #2 reset = 1'b0;
      out_ready = 1'b1;
      for (int b = 0; b < 9; b++) beat(splat(32'd1), 1'b0);
      check("rstp_fresh_valid", out_valid, 1'b1);
      check_lanes("rstp_fresh", 32'd9, 32'd9, 32'd9, 32'd9);
      tick();

      // Narrowing to 16 bits
`ifdef WINDOW_ACC_SAT_EN
      n_exp_pos = 16'h7FFF;
      n_exp_neg = 16'h8000;
`else
      n_exp_pos = 16'hFFF7;
      n_exp_neg = 16'h0000;
`endif
      n_in_valid = 1'b1;
      n_in_data  = 32'h7FFF_FFFF;
      repeat (9) tick();
      n_in_valid = 1'b0;
      check("narrow_pos_valid", n_out_valid, 1'b1);
      check("narrow_pos", n_out_data, n_exp_pos);
      tick();
      n_in_valid = 1'b1;
      n_in_data  = 32'h8000_0000;
      repeat (9) tick();
      n_in_valid = 1'b0;
      check("narrow_neg", n_out_data, n_exp_neg);
      tick();

      // TAPS=1: every beat completes; completion plus drain keeps valid high
      t_in_valid = 1'b1;
      t_in_data  = 16'hFD05;
      tick();
      check("t1_b0_valid", t_out_valid, 1'b1);
      check("t1_b0_data", t_out_data, 16'hFD05);
      t_in_data = 16'h807F;
      tick();
      check("t1_b1_valid", t_out_valid, 1'b1);
      check("t1_b1_data", t_out_data, 16'h807F);
      check("t1_b1_last", t_last, 1'b1);
      t_in_data = 16'h0100;
      tick();
      check("t1_b2_data", t_out_data, 16'h0100);
      t_in_valid = 1'b0;
      tick();
      check("t1_drop", t_out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
